// File: rtl/fifo_stream_reader.sv
// Consumer-side controller for the synchronous FIFO: pops words into a 2-entry
// buffer and presents them on a valid/ready master port. Optional delivered-word
// counter enabled by defining FIFO_STREAM_READER_COUNT_EN.
module fifo_stream_reader #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_read,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [CNT_W-1:0]  word_count
`endif
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              pop;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    pop        = m_valid && m_ready;
    m_data     = buf_q[head_q];
    busy       = m_valid || inflight_q;

    // occ + inflight never exceeds 2, so the 2-bit sum cannot overflow.
    occ_d      = occ_q + 2'(inflight_q) - 2'(pop);
    // Credit rule: only read when the word it returns is guaranteed a slot.
    fifo_read  = !reset && enable && !fifo_empty && (occ_d <= 2'd1);
    inflight_d = fifo_read;

    buf_d      = buf_q;
    tail_d     = tail_q;
    if (inflight_q) begin
      buf_d[tail_q] = fifo_dout;
      tail_d        = ~tail_q;
    end
    head_d     = pop ? ~head_q : head_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      // NOTE: the buffer is cleared on reset so m_data reads 0 afterwards;
      // it is only two words, so the reset fan-out is negligible.
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q      <= buf_d;
    end
  end

`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = pop ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign word_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed plus randomized bench for fifo_stream_reader; a behavioural FIFO and
// an in-order scoreboard supply every expected value.
module tb_fifo_stream_reader;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              m_ready = 1'b0;
  logic              fifo_empty;
  logic              fifo_read;
  logic              m_valid;
  logic              busy;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] m_data;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [CNT_W-1:0]  word_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  // Words pushed are kept in mem; wr_ptr = pushed, rd_ptr = popped by the
  // FIFO model, exp_ptr = next word the stream output must deliver.
  logic [31:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int exp_ptr = 0;
  int n_reads = 0;
  int delivered = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered read data, shares the reset.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= wr_ptr;
      fifo_dout <= '0;
    end else if (fifo_read) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Stream monitor: order, hold stability and never-read-when-empty.
  always @(negedge clk) begin
    if (reset) begin
      exp_ptr   = wr_ptr;
      prev_hold = 1'b0;
    end else begin
      if (fifo_empty) check("read_when_empty", 64'(fifo_read), 64'(0));
      if (fifo_read) n_reads++;
      if (prev_hold) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        check("word_expected", 64'(exp_ptr < wr_ptr), 64'(1));
        if (exp_ptr < wr_ptr) check("stream_order", 64'(m_data), 64'(mem[exp_ptr[7:0]]));
        exp_ptr++;
        delivered++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_ptr != wr_ptr && n < budget) begin
      nxt();
      n++;
    end
    check(tag, 64'(exp_ptr), 64'(wr_ptr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] rd_pat;
    logic [13:0] vd_pat;
    int rd0;
    int d0;
    int pushed;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fifo_read", 64'(fifo_read), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
`ifdef FIFO_STREAM_READER_COUNT_EN
    check("rst_word_count", 64'(word_count), 64'(0));
`endif
    nxt();
    reset = 1'b0;

    // Single word: read pulse, 2-cycle latency, one valid beat
    push(32'hA5A5_0001);
    enable  = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("single_read", 64'(fifo_read), 64'(1));
    nxt();
    @(negedge clk);
    check("single_read_off", 64'(fifo_read), 64'(0));
    check("single_not_yet", 64'(m_valid), 64'(0));
    check("single_busy", 64'(busy), 64'(1));
    nxt();
    @(negedge clk);
    check("single_valid", 64'(m_valid), 64'(1));
    check("single_data", 64'(m_data), 64'(32'hA5A5_0001));
    nxt();
    @(negedge clk);
    check("single_valid_off", 64'(m_valid), 64'(0));
    check("single_idle", 64'(busy), 64'(0));

    // Streaming: 8 back-to-back reads and 8 back-to-back beats
    nxt();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rd_pat[i] = fifo_read;
      vd_pat[i] = m_valid;
      nxt();
    end
    check("stream_read_pattern", 64'(rd_pat), 64'(14'b00_0000_1111_1111));
    check("stream_valid_pattern", 64'(vd_pat), 64'(14'b00_0011_1111_1100));
    check("stream_drained", 64'(exp_ptr), 64'(wr_ptr));

    // Backpressure: only two reads, first word held
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h20 + 32'(i));
    enable = 1'b1;
    rd0 = n_reads;
    repeat (6) nxt();
    check("bp_reads", 64'(n_reads - rd0), 64'(2));
    check("bp_fifo_left", 64'(wr_ptr - rd_ptr), 64'(3));
    @(negedge clk);
    check("bp_valid", 64'(m_valid), 64'(1));
    check("bp_data", 64'(m_data), 64'(32'h20));
    check("bp_no_read", 64'(fifo_read), 64'(0));
    check("bp_busy", 64'(busy), 64'(1));
    nxt();
    d0 = delivered;
    m_ready = 1'b1;
    wait_drain("bp_drain", 50);
    check("bp_delivered", 64'(delivered - d0), 64'(5));

    // Random ready and random FIFO arrivals over 100 words
    d0 = delivered;
    pushed = 0;
    n = 0;
    while ((pushed < 100 || exp_ptr != wr_ptr) && n < 3000) begin
      nxt();
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 100 && $urandom_range(0, 1) == 1) begin
        push($urandom);
        pushed++;
      end
      n++;
    end
    check("rand_drain", 64'(exp_ptr), 64'(wr_ptr));
    check("rand_delivered", 64'(delivered - d0), 64'(100));

    // enable dropped right after a read: in-flight word still delivered
    nxt();
    m_ready = 1'b1;
    enable  = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h30 + 32'(i));
    enable = 1'b1;
    @(negedge clk);
    check("en_read", 64'(fifo_read), 64'(1));
    nxt();
    enable = 1'b0;
    rd0 = n_reads;
    d0  = delivered;
    repeat (6) nxt();
    check("en_no_more_reads", 64'(n_reads - rd0), 64'(0));
    check("en_inflight_delivered", 64'(delivered - d0), 64'(1));
    @(negedge clk);
    check("en_idle", 64'(busy), 64'(0));

    // Reset with two words buffered
    nxt();
    m_ready = 1'b0;
    enable  = 1'b1;
    repeat (5) nxt();
    @(negedge clk);
    check("pre_rst_valid", 64'(m_valid), 64'(1));
    check("pre_rst_data", 64'(m_data), 64'(32'h31));
    nxt();
    reset = 1'b1;
    nxt();
    @(negedge clk);
    check("mid_rst_valid", 64'(m_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_read", 64'(fifo_read), 64'(0));
    check("mid_rst_data", 64'(m_data), 64'(0));
`ifdef FIFO_STREAM_READER_COUNT_EN
    check("mid_rst_count", 64'(word_count), 64'(0));
`endif
    nxt();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(m_valid), 64'(0));

`ifdef FIFO_STREAM_READER_COUNT_EN
    // Counter wraps: 18 words with a 4-bit counter leaves 2
    nxt();
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) push(32'h40 + 32'(i));
    enable = 1'b1;
    wait_drain("cnt_drain", 100);
    nxt();
    @(negedge clk);
    check("cnt_wrap", 64'(word_count), 64'(18 % 16));
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    @(negedge clk);
    check("cnt_reset", 64'(word_count), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side controller for the team's synchronous FIFO (read strobe, registered 1-cycle read data, empty flag).
- Pops words from the FIFO and presents them on a valid/ready streaming master port.
- Holds a 2-entry output buffer with a credit rule so back-to-back pops sustain one word per cycle.
- Sits between the FIFO and any downstream stream consumer.

Parameters:
- DATA_W, 32, word width; matches the FIFO data width.
- CNT_W, 16, width of the optional delivered-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, the block may issue FIFO reads.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_W  FIFO registered read data; valid in the cycle after a read.
- fifo_read  output  1  FIFO read strobe (combinational).
- m_valid  output  1  output word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_W  output word.
- busy  output  1  high while the output buffer is non-empty or a read is in flight.
- word_count  output  CNT_W  words delivered (present only with the optional feature).

Behaviour:
- State:
  - occ (0..2), the number of buffered words.
  - inflight, a 1-bit register equal to fifo_read delayed one cycle.
  - A 2-entry buffer with head/tail pointers, each 1 bit and wrapping 1->0.
- pop = m_valid && m_ready.
- fifo_read = !reset && enable && !fifo_empty && (occ + inflight - pop) <= 1.
  - This is a combinational path from m_ready and fifo_empty; it is accepted by design.
- Capture: when inflight = 1, fifo_dout is written into buffer[tail] at that edge, and tail increments.
- Latency: fifo_read high in cycle t -> word captured at the end of t+1 -> m_valid high in cycle t+2.
- occ_next = occ + inflight - pop.
  - Capture and pop in the same cycle leave occ unchanged.
  - The credit rule guarantees occ never exceeds 2 and a capture is never dropped.
- m_valid = (occ != 0).
- m_data = buffer[head]; head increments on pop.
- Stream rules:
  - Once m_valid is high, m_valid and m_data hold until pop.
  - Words leave in FIFO order.
  - There are no bubbles when the FIFO is non-empty and m_ready = 1 continuously (1 word/cycle after the 2-cycle fill).
- Empty boundary: fifo_empty = 1 forces fifo_read = 0. The block never strobes an empty FIFO.
- Full boundary: occ = 2, inflight = 0, pop = 0 -> no read. occ = 1, inflight = 1, pop = 0 -> no read.
- enable deassert: no new reads are issued. The in-flight word is still captured, and buffered words still drain.
- busy = (occ != 0) || inflight.
- Reset (also applies mid-operation):
  - occ = 0, inflight = 0, head = tail = 0, buffer contents = 0.
  - m_valid = 0, m_data = 0, busy = 0, fifo_read = 0, word_count = 0.
  - An in-flight word is discarded; the FIFO shares the same reset.

Optional Feature:
- Macro: FIFO_STREAM_READER_COUNT_EN.
- Defined:
  - The word_count port exists.
  - It increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
  - It resets to 0.
- Undefined:
  - The word_count port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Single word: FIFO holds 0xA5A5_0001, enable = 1, m_ready = 1 -> fifo_read pulses for exactly 1 cycle; m_valid high 2 cycles later for 1 cycle with m_data = 0xA5A5_0001; busy then low.
- Streaming: FIFO preloaded with 8 words 0x10..0x17, m_ready = 1 -> fifo_read high 8 consecutive cycles; m_valid high 8 consecutive cycles with data 0x10..0x17 in order; no read while fifo_empty = 1.
- Backpressure: 5 words preloaded, m_ready = 0 -> exactly 2 reads issued, occ = 2, m_data = first word held stable. Release m_ready -> remaining 3 words delivered in order with no loss or duplication.
- Random m_ready (50%) over 100 words -> output sequence equals input sequence; m_data is stable while m_valid && !m_ready; fifo_read is never high while fifo_empty = 1.
- enable dropped in the cycle after a read -> the in-flight word is still delivered and no further fifo_read occurs. Assert reset with 2 words buffered -> m_valid = 0 and busy = 0 the next cycle.
- With FIFO_STREAM_READER_COUNT_EN and CNT_W = 4, deliver 18 words -> word_count = 2 (wrapped). Reset -> word_count = 0.
